// File: rtl/stream_pkg.sv
// Shared definitions for the up-sampling output stream: widths, FSM encoding
// and the beat record carried through the output skid buffer.
package stream_pkg;

    localparam int AXIS_DATA_WIDTH = 32;
    localparam int AXIS_STRB_WIDTH = AXIS_DATA_WIDTH / 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] data;
        logic                       last;
        logic                       user;
    } beat_t;

    localparam int BEAT_WIDTH = $bits(beat_t);

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry valid/ready register buffer. Upstream ready is a flop, so it
// never depends combinationally on downstream ready.
module axis_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_allow,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_ready;

    logic             w_push;
    logic             w_pop;
    logic             w_wr_ptr;
    logic [1:0]       w_count_next;

    assign w_push   = i_valid & r_ready;
    assign w_pop    = (r_count != 2'd0) & i_ready;
    assign w_wr_ptr = r_rd_ptr ^ r_count[0];

    always_comb begin
        // NOTE: default assignment first so every path assigns w_count_next and no latch is inferred.
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_ready  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_next;
            r_ready <= i_allow & (w_count_next != 2'd2);
        end
    end

    // NOTE: storage has no reset; o_data is masked by o_valid, so stale entries never reach the port.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= i_data;
        end
    end

    assign o_ready = r_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/stream_out.sv
// AXI-Stream master forwarding up-sampled pixels to the output VDMA, with
// frame/row markers in tuser/tlast and an end-of-frame OUTEND pulse.
module stream_out
    import stream_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = stream_pkg::AXIS_DATA_WIDTH,
    parameter int UPSP_DATA_WIDTH = stream_pkg::AXIS_DATA_WIDTH,
    parameter int DST_IMG_WIDTH   = 3840,
    parameter int DST_IMG_HEIGHT  = 2160
) (
    input  logic                       m_axis_aclk,
    input  logic                       m_axis_arst,
    input  logic                       UPSTART,
    output logic                       OUTEND,
    input  logic                       upsp_ac_wvalid,
    input  logic [UPSP_DATA_WIDTH-1:0] upsp_ac_wdata,
    output logic                       ac_upsp_wready,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_STRB_WIDTH-1:0] m_axis_tstrb,
    output logic [AXIS_STRB_WIDTH-1:0] m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tuser,
    output logic                       m_axis_tid,
    output logic                       m_axis_tdest
);

    localparam int COL_W = (DST_IMG_WIDTH  > 1) ? $clog2(DST_IMG_WIDTH)  : 1;
    localparam int ROW_W = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(DST_IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DST_IMG_HEIGHT - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [COL_W-1:0] r_col_cnt;
    logic [ROW_W-1:0] r_row_cnt;
    logic             r_outend;

    logic             w_accept;
    logic             w_pop;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_out_valid;
    beat_t            w_in_beat;
    beat_t            w_out_beat;

    assign w_accept   = upsp_ac_wvalid & ac_upsp_wready;
    assign w_pop      = w_out_valid & m_axis_tready;
    assign w_col_last = (r_col_cnt == COL_LAST);
    assign w_row_last = (r_row_cnt == ROW_LAST);

    assign w_in_beat = '{
        data: upsp_ac_wdata,
        last: w_col_last,
        user: (r_col_cnt == '0) && (r_row_cnt == '0)
    };

    // Only the final beat of the frame can leave the buffer with tlast set while draining.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (UPSTART) w_state_next = ST_STREAM;
            ST_STREAM: if (w_accept && w_col_last && w_row_last) w_state_next = ST_DRAIN;
            ST_DRAIN:  if (w_pop && w_out_beat.last) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_arst) begin
            r_state   <= ST_IDLE;
            r_col_cnt <= '0;
            r_row_cnt <= '0;
            r_outend  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_outend <= (r_state == ST_DRAIN) && w_pop && w_out_beat.last;
            if (r_state == ST_IDLE && UPSTART) begin
                r_col_cnt <= '0;
                r_row_cnt <= '0;
            end else if (w_accept) begin
                if (w_col_last) begin
                    r_col_cnt <= '0;
                    r_row_cnt <= w_row_last ? '0 : r_row_cnt + 1'b1;
                end else begin
                    r_col_cnt <= r_col_cnt + 1'b1;
                end
            end
        end
    end

    axis_skid_buf #(
        .WIDTH (BEAT_WIDTH)
    ) u_skid (
        .i_clk   (m_axis_aclk),
        .i_rst   (m_axis_arst),
        .i_allow (w_state_next == ST_STREAM),
        .i_valid (upsp_ac_wvalid),
        .o_ready (ac_upsp_wready),
        .i_data  (w_in_beat),
        .o_valid (w_out_valid),
        .i_ready (m_axis_tready),
        .o_data  (w_out_beat)
    );

    assign OUTEND        = r_outend;
    assign m_axis_tvalid = w_out_valid;
    assign m_axis_tdata  = w_out_beat.data;
    assign m_axis_tlast  = w_out_beat.last;
    assign m_axis_tuser  = w_out_beat.user;
    assign m_axis_tstrb  = '1;
    assign m_axis_tkeep  = '1;
    assign m_axis_tid    = 1'b0;
    assign m_axis_tdest  = 1'b0;

endmodule

// File: tb/tb_stream_out.sv
// Self-checking bench for stream_out with a small 4x2 frame: a cycle table,
// directed corner sequences and randomized frames against a pixel-index model.
module tb_stream_out;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          upstart = 1'b0;
    logic          outend;
    logic          wvalid = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          wready;
    logic          tvalid;
    logic          tready = 1'b1;
    logic [DW-1:0] tdata;
    logic [3:0]    tstrb;
    logic [3:0]    tkeep;
    logic          tlast;
    logic          tuser;
    logic          tid;
    logic          tdest;

    always #5 clk = ~clk;

    stream_out #(
        .AXIS_DATA_WIDTH (DW),
        .UPSP_DATA_WIDTH (DW),
        .DST_IMG_WIDTH   (W),
        .DST_IMG_HEIGHT  (H)
    ) dut (
        .m_axis_aclk    (clk),
        .m_axis_arst    (arst),
        .UPSTART        (upstart),
        .OUTEND         (outend),
        .upsp_ac_wvalid (wvalid),
        .upsp_ac_wdata  (wdata),
        .ac_upsp_wready (wready),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready),
        .m_axis_tdata   (tdata),
        .m_axis_tstrb   (tstrb),
        .m_axis_tkeep   (tkeep),
        .m_axis_tlast   (tlast),
        .m_axis_tuser   (tuser),
        .m_axis_tid     (tid),
        .m_axis_tdest   (tdest)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: beat k of a frame carries last when k is the last column
    // of a row and user when k is the first pixel of the frame.
    logic [DW+1:0] exp_q [$];
    int            in_n = 0;
    int            out_n = 0;
    int            in_cnt = 0;
    int            out_cnt = 0;
    int            outend_cnt = 0;
    bit            exp_outend = 1'b0;
    bit            final_seen = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW+1:0] prev_beat = '0;
    logic [DW-1:0] first_data = '0;
    logic [DW-1:0] pix [N];

    always @(negedge clk) begin
        if (arst) begin
            exp_q.delete();
            in_n       = 0;
            out_n      = 0;
            exp_outend = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("outend_timing", outend, exp_outend);
            if (outend) outend_cnt++;
            exp_outend = 1'b0;
            if (prev_stall)
                check("stall_hold", {tvalid, tdata, tlast, tuser}, {1'b1, prev_beat});
            if (tvalid && tready) begin
                check("beat_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0)
                    check("beat_content", {tdata, tlast, tuser}, exp_q.pop_front());
                if (out_n == 0) first_data = tdata;
                out_n++;
                if (out_n == N) begin
                    out_n      = 0;
                    exp_outend = 1'b1;
                    final_seen = 1'b1;
                end
                out_cnt++;
            end
            if (wvalid && wready) begin
                exp_q.push_back({wdata, (in_n % W) == W - 1, in_n == 0});
                in_n = (in_n + 1) % N;
                in_cnt++;
            end
            prev_stall = tvalid && !tready;
            prev_beat  = {tdata, tlast, tuser};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst = 1'b1; upstart = 1'b0; wvalid = 1'b0; wdata = '0; tready = 1'b1;
        step();
        step();
        check("reset_state", {wready, tvalid, outend, tlast, tuser, tdata}, '0);
        arst = 1'b0;
    endtask

    task automatic idle(input int n);
        upstart = 1'b0; wvalid = 1'b0; tready = 1'b1;
        repeat (n) step();
    endtask

    // mode 0: tready=1; 1: tready=0 for first 6 cycles; 2: random wvalid,
    // toggling tready; 3: like 0 with UPSTART held while draining.
    task automatic run_frame(input int mode, input int stop_after);
        bit done;
        done = 1'b0;
        in_cnt = 0; out_cnt = 0; outend_cnt = 0; final_seen = 1'b0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (final_seen || (stop_after > 0 && out_cnt >= stop_after)) begin
                done = 1'b1;
            end else begin
                upstart = (cyc == 0) || (mode == 3 && in_cnt == N);
                wvalid  = (in_cnt < N) && (mode != 2 || $urandom_range(0, 1) == 1);
                wdata   = (in_cnt < N) ? pix[in_cnt] : '0;
                tready  = (mode == 1) ? (cyc > 5) : (mode == 2) ? (cyc % 2 == 1) : 1'b1;
                if (mode == 1 && cyc == 5) begin
                    check("stall_wready_low", wready, 0);
                    check("stall_absorbed", in_cnt, 2);
                end
                step();
            end
        end
        check("frame_complete", done, 1);
        upstart = 1'b0; wvalid = 1'b0; tready = 1'b1;
    endtask

    task automatic fill_seq();
        for (int i = 0; i < N; i++) pix[i] = DW'(i + 1);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++) pix[i] = $urandom;
    endtask

    typedef struct {
        logic          up;
        logic          wv;
        logic [DW-1:0] wd;
        logic          wr;
        logic          tv;
        logic [DW-1:0] td;
        logic          tl;
        logic          tu;
        logic          oe;
    } vec_t;

    function automatic vec_t mk(logic up, logic wv, logic [DW-1:0] wd, logic wr, logic tv,
                                logic [DW-1:0] td, logic tl, logic tu, logic oe);
        vec_t v;
        v.up = up; v.wv = wv; v.wd = wd; v.wr = wr; v.tv = tv;
        v.td = td; v.tl = tl; v.tu = tu; v.oe = oe;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl [12];
        tbl[0]  = mk(1, 0, 32'h00, 0, 0, 32'h00, 0, 0, 0);
        tbl[1]  = mk(0, 1, 32'h01, 1, 0, 32'h00, 0, 0, 0);
        tbl[2]  = mk(0, 1, 32'h02, 1, 1, 32'h01, 0, 1, 0);
        tbl[3]  = mk(0, 1, 32'h03, 1, 1, 32'h02, 0, 0, 0);
        tbl[4]  = mk(0, 1, 32'h04, 1, 1, 32'h03, 0, 0, 0);
        tbl[5]  = mk(0, 1, 32'h05, 1, 1, 32'h04, 1, 0, 0);
        tbl[6]  = mk(0, 1, 32'h06, 1, 1, 32'h05, 0, 0, 0);
        tbl[7]  = mk(0, 1, 32'h07, 1, 1, 32'h06, 0, 0, 0);
        tbl[8]  = mk(0, 1, 32'h08, 1, 1, 32'h07, 0, 0, 0);
        tbl[9]  = mk(0, 0, 32'h00, 0, 1, 32'h08, 1, 0, 0);
        tbl[10] = mk(0, 0, 32'h00, 0, 0, 32'h00, 0, 0, 1);
        tbl[11] = mk(0, 0, 32'h00, 0, 0, 32'h00, 0, 0, 0);

        do_reset();
        check("static_sidebands", {tstrb, tkeep, tid, tdest}, {4'hF, 4'hF, 2'b00});

        // Cycle-exact frame with tready held high.
        for (int i = 0; i < 12; i++) begin
            upstart = tbl[i].up; wvalid = tbl[i].wv; wdata = tbl[i].wd; tready = 1'b1;
            check($sformatf("table_cycle_%0d", i),
                  {wready, tvalid, tdata, tlast, tuser, outend},
                  {tbl[i].wr, tbl[i].tv, tbl[i].td, tbl[i].tl, tbl[i].tu, tbl[i].oe});
            step();
        end
        idle(2);

        // Downstream stall at frame start.
        fill_seq();
        run_frame(1, 0);
        check("stall_beat_count", out_cnt, N);
        idle(3);

        // Random wvalid with tready toggling.
        for (int f = 0; f < 3; f++) begin
            fill_rand();
            run_frame(2, 0);
            check("rand_beat_count", out_cnt, N);
            check("rand_in_count", in_cnt, N);
            idle(3);
        end

        // wvalid with 0xAA held before UPSTART is not consumed.
        in_cnt = 0;
        upstart = 1'b0; wvalid = 1'b1; wdata = 32'hAA; tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_wready", wready, 0);
            check("idle_tvalid", tvalid, 0);
        end
        check("idle_no_accept", in_cnt, 0);
        fill_rand();
        pix[0] = 32'hAA;
        run_frame(0, 0);
        check("aa_first_beat", first_data, 32'hAA);
        idle(3);

        // Reset three beats into a frame, then a clean restart.
        fill_seq();
        run_frame(0, 3);
        arst = 1'b1;
        step();
        check("midrst_outputs", {tvalid, wready, outend}, 3'b000);
        arst = 1'b0;
        idle(4);
        check("midrst_no_outend", outend_cnt, 0);
        fill_rand();
        run_frame(0, 0);
        check("restart_first_beat", first_data, pix[0]);
        check("restart_beat_count", out_cnt, N);
        idle(3);

        // UPSTART while draining is ignored.
        fill_seq();
        run_frame(3, 0);
        idle(6);
        check("drain_upstart_outend_cnt", outend_cnt, 1);
        check("drain_upstart_idle", {wready, tvalid}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
